// File: rtl/hs4_responder_if.sv
// Four-phase req/ack link carrying one payload word from initiator to responder.
interface hs4_responder_if #(
  parameter int DATA_W = 8
) ();
  logic              req_i;
  logic [DATA_W-1:0] data_i;
  logic              ack_o;

  modport master (output req_i, output data_i, input ack_o);
  modport slave  (input req_i, input data_i, output ack_o);
endinterface

// File: rtl/hs4_responder.sv
// Passive end of a four-phase req/ack handshake with programmable ack delay and watchdog.
// Define HS4_RESP_SYNC_EN to pass req_i through a 2-flop synchroniser for an async initiator.
module hs4_responder #(
  parameter int DATA_W  = 8,
  parameter int ACK_DLY = 2,
  parameter int TOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  hs4_responder_if.slave    link,
  input  logic              hold_i,
  input  logic              err_clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    ACK,
    DRAIN
  } state_t;

  // One extra count of headroom so the saturated value still satisfies the threshold.
  localparam int DLY_W    = $clog2(ACK_DLY + 2);
  localparam int TO_W     = $clog2(TOUT + 2);
  localparam bit DLY_ZERO = (ACK_DLY == 0);
  localparam bit WD_EN    = (TOUT != 0);

  state_t            r_state;
  logic [DLY_W-1:0]  r_dly_cnt;
  logic [TO_W-1:0]   r_wd_cnt;
  logic              r_ack;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_err;

  logic              w_req_s;
  logic [DLY_W-1:0]  w_dly_next;
  logic [TO_W-1:0]   w_wd_next;
  logic              w_dly_done;
  logic              w_wd_done;
  logic              w_err_set;

`ifdef HS4_RESP_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], link.req_i};
    end
  end

  assign w_req_s = r_sync[1];
`else
  assign w_req_s = link.req_i;
`endif

  // Saturating increments: a long hold or stuck requester must never wrap a counter.
  assign w_dly_next = (r_dly_cnt == '1) ? r_dly_cnt : r_dly_cnt + DLY_W'(1);
  assign w_wd_next  = (r_wd_cnt == '1)  ? r_wd_cnt  : r_wd_cnt + TO_W'(1);
  assign w_dly_done = (int'(w_dly_next) >= ACK_DLY);
  assign w_wd_done  = WD_EN && (int'(w_wd_next) >= TOUT);

  assign w_err_set = ((r_state == DELAY) && !w_req_s) ||
                     ((r_state == ACK) && w_req_s && w_wd_done);

  // NOTE: all state below is written with <= so every branch sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_dly_cnt <= '0;
      r_wd_cnt  <= '0;
      r_ack     <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_req_s) begin
            r_dly_cnt <= '0;
            if (DLY_ZERO && !hold_i) begin
              r_state  <= ACK;
              r_ack    <= 1'b1;
              r_data   <= link.data_i;
              r_valid  <= 1'b1;
              r_wd_cnt <= '0;
            end else begin
              r_state <= DELAY;
            end
          end
        end

        DELAY: begin
          if (!w_req_s) begin
            r_state <= IDLE;
          end else begin
            r_dly_cnt <= w_dly_next;
            if (w_dly_done && !hold_i) begin
              r_state  <= ACK;
              r_ack    <= 1'b1;
              r_data   <= link.data_i;
              r_valid  <= 1'b1;
              r_wd_cnt <= '0;
            end
          end
        end

        ACK: begin
          if (!w_req_s) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
          end else begin
            r_wd_cnt <= w_wd_next;
            if (w_wd_done) begin
              r_state <= DRAIN;
              r_ack   <= 1'b0;
            end
          end
        end

        DRAIN: begin
          if (!w_req_s) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
        end
      endcase

      // A new error outranks a clear arriving in the same cycle.
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (err_clr_i) begin
        r_err <= 1'b0;
      end
    end
  end

  assign link.ack_o = r_ack;
  assign data_o     = r_data;
  assign valid_o    = r_valid;
  assign busy_o     = (r_state != IDLE);
  assign err_o      = r_err;

endmodule

// File: tb/tb_hs4_responder.sv
// Directed bench for hs4_responder: four instances cover the default, short-timeout,
// long-delay and zero-delay/no-watchdog parameter sets.
module tb_hs4_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic hold;
  logic err_clr;

  int errors = 0;
  int checks = 0;

  // a: ACK_DLY=2 TOUT=16, t: ACK_DLY=2 TOUT=4, w: ACK_DLY=5 TOUT=16, z: ACK_DLY=0 TOUT=0
  hs4_responder_if #(.DATA_W(8)) if_a ();
  hs4_responder_if #(.DATA_W(8)) if_t ();
  hs4_responder_if #(.DATA_W(8)) if_w ();
  hs4_responder_if #(.DATA_W(8)) if_z ();

  logic [7:0] data_a, data_t, data_w, data_z;
  logic       valid_a, valid_t, valid_w, valid_z;
  logic       busy_a, busy_t, busy_w, busy_z;
  logic       err_a, err_t, err_w, err_z;

  hs4_responder #(.DATA_W(8), .ACK_DLY(2), .TOUT(16)) u_dut_a (
    .clk(clk), .rst(rst), .link(if_a.slave), .hold_i(hold), .err_clr_i(err_clr),
    .data_o(data_a), .valid_o(valid_a), .busy_o(busy_a), .err_o(err_a));

  hs4_responder #(.DATA_W(8), .ACK_DLY(2), .TOUT(4)) u_dut_t (
    .clk(clk), .rst(rst), .link(if_t.slave), .hold_i(hold), .err_clr_i(err_clr),
    .data_o(data_t), .valid_o(valid_t), .busy_o(busy_t), .err_o(err_t));

  hs4_responder #(.DATA_W(8), .ACK_DLY(5), .TOUT(16)) u_dut_w (
    .clk(clk), .rst(rst), .link(if_w.slave), .hold_i(hold), .err_clr_i(err_clr),
    .data_o(data_w), .valid_o(valid_w), .busy_o(busy_w), .err_o(err_w));

  hs4_responder #(.DATA_W(8), .ACK_DLY(0), .TOUT(0)) u_dut_z (
    .clk(clk), .rst(rst), .link(if_z.slave), .hold_i(hold), .err_clr_i(err_clr),
    .data_o(data_z), .valid_o(valid_z), .busy_o(busy_z), .err_o(err_z));

  // Pulse counters sample at the edge, so a pulse is counted one edge after it appears.
  int vcnt_a = 0;
  int vcnt_w = 0;
  always @(posedge clk) begin
    if (valid_a) vcnt_a++;
    if (valid_w) vcnt_w++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    checks++; if (if_a.ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", if_a.ack_o); end
    checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_a); end
    checks++; if (if_z.ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack_z: got %b want 0", if_z.ack_o); end
  endtask

  task automatic test_basic();
    int v0;
    v0 = vcnt_a;
    if_a.req_i = 1'b1; if_a.data_i = 8'hA5;
    tick();  // edge N
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy_a); end
    checks++; if (if_a.ack_o !== 1'b0) begin errors++; $display("FAIL basic_ack_n: got %b want 0", if_a.ack_o); end
    tick();  // N+1
    checks++; if (if_a.ack_o !== 1'b0) begin errors++; $display("FAIL basic_ack_n1: got %b want 0", if_a.ack_o); end
    tick();  // N+2
    checks++; if (if_a.ack_o !== 1'b1) begin errors++; $display("FAIL basic_ack_rise: got %b want 1", if_a.ack_o); end
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", valid_a); end
    checks++; if (data_a !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", data_a); end
    if_a.data_i = 8'h3C;
    tick();
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got %b want 0", valid_a); end
    checks++; if (data_a !== 8'hA5) begin errors++; $display("FAIL basic_data_hold: got %h want a5", data_a); end
    if_a.req_i = 1'b0;
    tick();  // edge M
    checks++; if (if_a.ack_o !== 1'b0) begin errors++; $display("FAIL basic_ack_fall: got %b want 0", if_a.ack_o); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b want 0", busy_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err_a); end
    tick();
    checks++; if (vcnt_a - v0 !== 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", vcnt_a - v0); end
  endtask

  task automatic test_back_to_back();
    if_a.req_i = 1'b1; if_a.data_i = 8'h11;
    tick(3);
    checks++; if (if_a.ack_o !== 1'b1) begin errors++; $display("FAIL b2b_ack1: got %b want 1", if_a.ack_o); end
    if_a.req_i = 1'b0;
    tick();  // edge M
    if_a.req_i = 1'b1; if_a.data_i = 8'h5A;
    tick();  // M+1 accepts the new request
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b want 1", busy_a); end
    tick(2);
    checks++; if (if_a.ack_o !== 1'b1) begin errors++; $display("FAIL b2b_ack2: got %b want 1", if_a.ack_o); end
    checks++; if (data_a !== 8'h5A) begin errors++; $display("FAIL b2b_data: got %h want 5a", data_a); end
    if_a.req_i = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int v0;
    v0 = vcnt_a;
    hold = 1'b1;
    if_a.req_i = 1'b1; if_a.data_i = 8'hC3;
    for (int i = 0; i < 5; i++) begin  // edges N..N+4 held
      tick();
      checks++; if (if_a.ack_o !== 1'b0) begin errors++; $display("FAIL bp_held_%0d: got %b want 0", i, if_a.ack_o); end
    end
    hold = 1'b0;
    tick();  // N+5
    checks++; if (if_a.ack_o !== 1'b1) begin errors++; $display("FAIL bp_ack: got %b want 1", if_a.ack_o); end
    checks++; if (data_a !== 8'hC3) begin errors++; $display("FAIL bp_data: got %h want c3", data_a); end
    if_a.req_i = 1'b0;
    tick(2);
    checks++; if (vcnt_a - v0 !== 1) begin errors++; $display("FAIL bp_pulses: got %0d want 1", vcnt_a - v0); end
  endtask

  task automatic test_timeout();
    if_t.req_i = 1'b1; if_t.data_i = 8'h77;
    tick(2);
    checks++; if (if_t.ack_o !== 1'b0) begin errors++; $display("FAIL to_pre: got %b want 0", if_t.ack_o); end
    tick();  // edge A
    for (int i = 0; i < 4; i++) begin
      checks++; if (if_t.ack_o !== 1'b1) begin errors++; $display("FAIL to_high_%0d: got %b want 1", i, if_t.ack_o); end
      tick();
    end
    // now after edge A+4
    checks++; if (if_t.ack_o !== 1'b0) begin errors++; $display("FAIL to_drop: got %b want 0", if_t.ack_o); end
    checks++; if (err_t !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", err_t); end
    tick(5);
    checks++; if (if_t.ack_o !== 1'b0) begin errors++; $display("FAIL to_drain_ack: got %b want 0", if_t.ack_o); end
    checks++; if (busy_t !== 1'b1) begin errors++; $display("FAIL to_drain_busy: got %b want 1", busy_t); end
    if_t.req_i = 1'b0;
    tick();
    checks++; if (busy_t !== 1'b0) begin errors++; $display("FAIL to_release: got %b want 0", busy_t); end
    checks++; if (err_t !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", err_t); end
    if_t.req_i = 1'b1;
    tick(3);
    checks++; if (if_t.ack_o !== 1'b1) begin errors++; $display("FAIL to_reack: got %b want 1", if_t.ack_o); end
    if_t.req_i = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err_t !== 1'b0) begin errors++; $display("FAIL to_clr: got %b want 0", err_t); end
  endtask

  task automatic test_withdrawal();
    int v0;
    v0 = vcnt_w;
    if_w.req_i = 1'b1; if_w.data_i = 8'h99;
    tick(2);
    if_w.req_i = 1'b0;
    tick();
    checks++; if (if_w.ack_o !== 1'b0) begin errors++; $display("FAIL wd_ack: got %b want 0", if_w.ack_o); end
    checks++; if (err_w !== 1'b1) begin errors++; $display("FAIL wd_err: got %b want 1", err_w); end
    checks++; if (busy_w !== 1'b0) begin errors++; $display("FAIL wd_idle: got %b want 0", busy_w); end
    checks++; if (data_w !== 8'h00) begin errors++; $display("FAIL wd_nocapture: got %h want 00", data_w); end
    tick();
    checks++; if (vcnt_w - v0 !== 0) begin errors++; $display("FAIL wd_novalid: got %0d want 0", vcnt_w - v0); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err_w !== 1'b0) begin errors++; $display("FAIL wd_clr: got %b want 0", err_w); end
    // withdrawal and clear on the same edge
    if_w.req_i = 1'b1;
    tick();
    if_w.req_i = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err_w !== 1'b1) begin errors++; $display("FAIL wd_set_wins: got %b want 1", err_w); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_zero_delay();
    if_z.req_i = 1'b1; if_z.data_i = 8'hE7;
    tick();
    checks++; if (if_z.ack_o !== 1'b1) begin errors++; $display("FAIL zd_ack: got %b want 1", if_z.ack_o); end
    checks++; if (valid_z !== 1'b1) begin errors++; $display("FAIL zd_valid: got %b want 1", valid_z); end
    checks++; if (data_z !== 8'hE7) begin errors++; $display("FAIL zd_data: got %h want e7", data_z); end
    tick(40);
    checks++; if (if_z.ack_o !== 1'b1) begin errors++; $display("FAIL zd_nowd_ack: got %b want 1", if_z.ack_o); end
    checks++; if (err_z !== 1'b0) begin errors++; $display("FAIL zd_nowd_err: got %b want 0", err_z); end
    if_z.req_i = 1'b0;
    tick();
    checks++; if (if_z.ack_o !== 1'b0) begin errors++; $display("FAIL zd_fall: got %b want 0", if_z.ack_o); end
  endtask

  task automatic test_reset_mid_ack();
    int v0;
    if_a.req_i = 1'b1; if_a.data_i = 8'h2D;
    tick(3);
    checks++; if (if_a.ack_o !== 1'b1) begin errors++; $display("FAIL rm_pre: got %b want 1", if_a.ack_o); end
    rst = 1'b1;
    tick();
    checks++; if (if_a.ack_o !== 1'b0) begin errors++; $display("FAIL rm_ack: got %b want 0", if_a.ack_o); end
    checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL rm_data: got %h want 00", data_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", valid_a); end
    rst = 1'b0;
    if_a.data_i = 8'h4B;
    v0 = vcnt_a;
    tick(2);
    checks++; if (if_a.ack_o !== 1'b0) begin errors++; $display("FAIL rm_wait: got %b want 0", if_a.ack_o); end
    tick();
    checks++; if (if_a.ack_o !== 1'b1) begin errors++; $display("FAIL rm_reack: got %b want 1", if_a.ack_o); end
    checks++; if (data_a !== 8'h4B) begin errors++; $display("FAIL rm_data2: got %h want 4b", data_a); end
    if_a.req_i = 1'b0;
    tick(2);
    checks++; if (vcnt_a - v0 !== 1) begin errors++; $display("FAIL rm_pulses: got %0d want 1", vcnt_a - v0); end
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; err_clr = 1'b0;
    if_a.req_i = 1'b0; if_a.data_i = '0;
    if_t.req_i = 1'b0; if_t.data_i = '0;
    if_w.req_i = 1'b0; if_w.data_i = '0;
    if_z.req_i = 1'b0; if_z.data_i = '0;
    tick(2);
    test_reset();
    rst = 1'b0;
    tick();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_withdrawal();
    test_zero_delay();
    test_reset_mid_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
